register_mode_cfg_ctrl: RTL and testbench
=========================================

# register_mode_cfg_ctrl

Configuration controller for a bank of `NUM_REGS` RegisterMode slots. It arbitrates round-robin between two configuration requesters and owns the per-slot 2-bit mode registers. It sequences one-cycle `config_we` write pulses into the selected slot and returns read-back or acknowledge responses. It sits between the config bus and the RegisterMode bank, and gates the bank's `clk_en` while a write is in flight.

## Interface
Parameters:
- `NUM_REGS`, 4: number of RegisterMode slots
- `WIDTH`, 4: data width of each slot (`value`, `const_`, `config_data`)
- `ADDR_W`, 2: slot-index width; request address is `ADDR_W+1` bits

Ports (`i` ∈ {0,1} for the two requester ports):
- `CLK` input 1: single clock, all state updates on rising edge
- `RESETN` input 1: synchronous, active-low reset
- `req_valid_i` input 1: request present on port i
- `req_ready_i` output 1: port i request accepted this cycle
- `req_write_i` input 1: 1 = write, 0 = read
- `req_addr_i` input `ADDR_W+1`:
  - MSB=0: data space of slot `addr[ADDR_W-1:0]`
  - MSB=1: mode register of that slot
- `req_data_i` input `WIDTH`: write data
- `resp_valid_i` output 1: response pending on port i
- `resp_ready_i` input 1: port i consumes the response
- `resp_data_i` output `WIDTH`: read data, or echoed write data
- `run_en` input 1: global run enable for the bank
- `reg_value` input `NUM_REGS*WIDTH`: slot outputs; slot s at `[s*WIDTH +: WIDTH]`
- `mode` output `2*NUM_REGS`: per-slot mode; slot s at `[2s+1:2s]`
- `config_we` output `NUM_REGS`: one-hot write strobe
- `config_data` output `WIDTH`: shared write data to all slots
- `clk_en` output 1: clock enable to all slots

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant arbitration: round-robin over the ports with `req_valid`. `last_grant` stores the port served most recently; on a tie, the other port wins.
  - `req_ready_i` = (state==IDLE) & grant_i, driven combinationally. At most one port is ready per cycle.
  - On handshake: latch port id, write flag, address and data; go to EXEC; update `last_grant`.
- **EXEC** (exactly 1 cycle), data-space write:
  - `config_we[slot]`=1 for this cycle only.
  - `config_data` = latched data.
  - `clk_en`=0.
- **EXEC**, mode write: `mode[slot]` ← `data[1:0]` at the end of EXEC. Value 2'b11 is stored unchanged. No `config_we`.
- **EXEC**, data read: sample `reg_value[slot]` into the response register.
- **EXEC**, mode read: response = `mode[slot]` zero-extended to `WIDTH`.
- **EXEC**, any write: response = latched write data.
- **EXEC** then always transitions to RESP.
- **RESP**
  - `resp_valid` asserted on the latched port only; `resp_data` held stable.
  - Leave to IDLE on `resp_ready` of that port. No new request is accepted until the cycle after.
- **Out-of-range slot** (slot ≥ `NUM_REGS`): writes produce no strobe and no mode change; reads return 0; a response is still generated.
- **Outputs outside EXEC**:
  - `config_we` = 0.
  - `config_data` holds its last value.
  - `clk_en` = `run_en` except during a data-space write EXEC, where it is 0.

## Timing
- Reset values (`RESETN` low at an edge):
  - state IDLE; `mode` all 0; `config_we` 0; `config_data` 0.
  - `resp_valid` 0 on both ports; `resp_data` 0; `req_ready` 0.
  - `last_grant` = 1, so port 0 wins the first tie.
  - `clk_en` = 0 while `RESETN` is low.
- Latency: handshake at edge N → EXEC in cycle N+1 → `resp_valid` high in cycle N+2.
- Minimum request-to-request spacing on one port is 3 cycles (response consumed immediately).
- Reset mid-operation: in-flight request dropped; no `config_we` pulse issued; no response generated.
- Same-cycle `req_valid` on both ports: exactly one handshake, per round-robin. The loser stays valid and is granted on the next IDLE.
- `resp_ready` low: stays in RESP indefinitely. A new `req_valid` on the other port is not accepted meanwhile.
- Read-back captures `reg_value` as seen during EXEC. Slot updates from `config_we` are visible on a read issued afterwards, not on the same EXEC.

## Test plan
- Reset, then port 0 writes addr 0b001, data 4'hA → `config_we`=4'b0010 for exactly one cycle, `config_data`=4'hA, `clk_en`=0 that cycle; `resp_valid_0` 2 cycles after handshake with `resp_data_0`=4'hA.
- Port 1 writes mode addr 0b110, data 4'h1, then reads 0b110 → `mode[5:4]`=2'b01, no `config_we` pulse; read response 4'h1.
- Both ports valid continuously after reset → grants alternate 0,1,0,1. No port is granted twice while the other waits.
- Read data slot 3 with `reg_value[15:12]`=4'h7 during EXEC → `resp_data`=4'h7. Hold `resp_ready` low 5 cycles → `resp_valid` and data stable, no new acceptance.
- Assert `RESETN`=0 during EXEC of a write → no `config_we` pulse; `resp_valid`=0; `mode` cleared to 0; next request is served normally.
- With `NUM_REGS`=3, write slot 3 → `config_we` stays 0; write response still returned; read of slot 3 returns 0.

Source files
------------

// File: rtl/register_mode_cfg_ctrl.sv
// Configuration controller for a bank of RegisterMode slots: round-robin arbitration of two
// requesters, per-slot mode registers, one-cycle config_we strobes and read-back responses.
module register_mode_cfg_ctrl #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned ADDR_W   = 2
) (
  input  logic                        CLK,
  input  logic                        RESETN,
  input  logic                        req_valid_0,
  output logic                        req_ready_0,
  input  logic                        req_write_0,
  input  logic [ADDR_W:0]             req_addr_0,
  input  logic [WIDTH-1:0]            req_data_0,
  output logic                        resp_valid_0,
  input  logic                        resp_ready_0,
  output logic [WIDTH-1:0]            resp_data_0,
  input  logic                        req_valid_1,
  output logic                        req_ready_1,
  input  logic                        req_write_1,
  input  logic [ADDR_W:0]             req_addr_1,
  input  logic [WIDTH-1:0]            req_data_1,
  output logic                        resp_valid_1,
  input  logic                        resp_ready_1,
  output logic [WIDTH-1:0]            resp_data_1,
  input  logic                        run_en,
  input  logic [NUM_REGS*WIDTH-1:0]   reg_value,
  output logic [2*NUM_REGS-1:0]       mode,
  output logic [NUM_REGS-1:0]         config_we,
  output logic [WIDTH-1:0]            config_data,
  output logic                        clk_en
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              last_grant;
  logic              grant_0, grant_1;
  logic              hs, hs_port;
  logic              sel_write;
  logic [ADDR_W:0]   sel_addr;
  logic [WIDTH-1:0]  sel_data;

  logic              cur_port, cur_write;
  logic [ADDR_W:0]   cur_addr;
  logic [WIDTH-1:0]  cur_data;
  logic [ADDR_W-1:0] cur_slot;
  logic              cur_is_mode;

  logic [NUM_REGS-1:0] slot_sel;
  logic [WIDTH-1:0]    rd_value;
  logic [1:0]          rd_mode;
  logic [WIDTH-1:0]    resp_nxt;
  logic                data_wr;
  logic                resp_take;

  assign cur_slot    = cur_addr[ADDR_W-1:0];
  assign cur_is_mode = cur_addr[ADDR_W];

  // Round-robin: on a tie the port not served last wins.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      grant_0 = last_grant;
      grant_1 = !last_grant;
    end else begin
      grant_0 = req_valid_0;
      grant_1 = req_valid_1;
    end
  end

  assign hs        = req_ready_0 || req_ready_1;
  assign hs_port   = req_ready_1;
  assign sel_write = hs_port ? req_write_1 : req_write_0;
  assign sel_addr  = hs_port ? req_addr_1  : req_addr_0;
  assign sel_data  = hs_port ? req_data_1  : req_data_0;

  // Slot decode; an out-of-range slot selects nothing and reads back zero.
  always_comb begin
    slot_sel = '0;
    rd_value = '0;
    rd_mode  = '0;
    for (int unsigned s = 0; s < NUM_REGS; s++) begin
      if (cur_slot == ADDR_W'(s)) begin
        slot_sel[s] = 1'b1;
        rd_value    = reg_value[s*WIDTH +: WIDTH];
        rd_mode     = mode[2*s +: 2];
      end
    end
  end

  assign resp_nxt  = cur_write ? cur_data : (cur_is_mode ? WIDTH'(rd_mode) : rd_value);
  assign data_wr   = (state == EXEC) && cur_write && !cur_is_mode;
  assign resp_take = cur_port ? resp_ready_1 : resp_ready_0;

  always_ff @(posedge CLK) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    config_we   = '0;
    clk_en      = RESETN && run_en && !data_wr;
    unique case (state)
      IDLE: begin
        req_ready_0 = RESETN && grant_0;
        req_ready_1 = RESETN && grant_1;
        if (RESETN && (grant_0 || grant_1)) state_nxt = EXEC;
      end
      EXEC: begin
        if (data_wr && RESETN) config_we = slot_sel;
        state_nxt = RESP;
      end
      RESP: begin
        if (resp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, mode registers and per-port response registers.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      last_grant   <= 1'b1;
      cur_port     <= 1'b0;
      cur_write    <= 1'b0;
      cur_addr     <= '0;
      cur_data     <= '0;
      config_data  <= '0;
      mode         <= '0;
      resp_valid_0 <= 1'b0;
      resp_valid_1 <= 1'b0;
      resp_data_0  <= '0;
      resp_data_1  <= '0;
    end else begin
      if (hs) begin
        last_grant <= hs_port;
        cur_port   <= hs_port;
        cur_write  <= sel_write;
        cur_addr   <= sel_addr;
        cur_data   <= sel_data;
        if (sel_write && !sel_addr[ADDR_W]) config_data <= sel_data;
      end
      if (state == EXEC) begin
        if (cur_port) begin
          resp_valid_1 <= 1'b1;
          resp_data_1  <= resp_nxt;
        end else begin
          resp_valid_0 <= 1'b1;
          resp_data_0  <= resp_nxt;
        end
        if (cur_write && cur_is_mode) begin
          for (int unsigned s = 0; s < NUM_REGS; s++) begin
            if (slot_sel[s]) mode[2*s +: 2] <= cur_data[1:0];
          end
        end
      end
      if ((state == RESP) && resp_take) begin
        if (cur_port) resp_valid_1 <= 1'b0;
        else          resp_valid_0 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_mode_cfg_ctrl.sv
// Randomized scoreboard bench for register_mode_cfg_ctrl (built with NUM_REGS=3 so slot 3 is out of range).
module tb_register_mode_cfg_ctrl;

  localparam int unsigned N   = 3;
  localparam int unsigned W   = 4;
  localparam int unsigned AW  = 2;
  localparam int unsigned RVW = N*W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          req_valid_0, req_ready_0, req_write_0;
  logic [AW:0]   req_addr_0;
  logic [W-1:0]  req_data_0;
  logic          resp_valid_0, resp_ready_0;
  logic [W-1:0]  resp_data_0;
  logic          req_valid_1, req_ready_1, req_write_1;
  logic [AW:0]   req_addr_1;
  logic [W-1:0]  req_data_1;
  logic          resp_valid_1, resp_ready_1;
  logic [W-1:0]  resp_data_1;
  logic          run_en;
  logic [RVW-1:0] reg_value;
  logic [2*N-1:0] mode;
  logic [N-1:0]  config_we;
  logic [W-1:0]  config_data;
  logic          clk_en;

  register_mode_cfg_ctrl #(.NUM_REGS(N), .WIDTH(W), .ADDR_W(AW)) dut (
    .CLK(clk), .RESETN(resetn),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_write_0(req_write_0),
    .req_addr_0(req_addr_0), .req_data_0(req_data_0),
    .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0), .resp_data_0(resp_data_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_write_1(req_write_1),
    .req_addr_1(req_addr_1), .req_data_1(req_data_1),
    .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1), .resp_data_1(resp_data_1),
    .run_en(run_en), .reg_value(reg_value), .mode(mode),
    .config_we(config_we), .config_data(config_data), .clk_en(clk_en)
  );

  typedef struct { bit write; bit [AW:0] addr; bit [W-1:0] data; } req_t;
  typedef struct { int port; bit [W-1:0] data; } resp_t;

  int errors = 0;
  int checks = 0;

  resp_t   exp_q[$];
  int      grant_log[$];
  req_t    pend[2];
  bit      has_pend[2];
  bit      busy;
  int      last_port;
  bit [1:0] m_mode[N];
  bit [W-1:0] m_cfg;
  bit      exec_now;
  req_t    exec_req;
  bit      rst_in_exec;
  bit      gen_en;
  int      refill;
  int      hold_req;
  int      since_grant;
  int      lat_port;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.write = 1'($urandom_range(0, 1));
    r.addr  = (AW+1)'($urandom_range(0, 7));
    r.data  = W'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic req_t mk(input bit wr, input bit [AW:0] a, input bit [W-1:0] d);
    req_t r;
    r.write = wr;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

  function automatic logic [2*N-1:0] mode_vec();
    logic [2*N-1:0] v;
    for (int s = 0; s < N; s++) v[2*s +: 2] = m_mode[s];
    return v;
  endfunction

  // Response monitor: pops the scoreboard when a response appears and drives resp_ready.
  initial begin : monitor
    bit    have;
    bit    consumed;
    int    hold;
    resp_t cur;
    have = 0; consumed = 0; hold = 0;
    resp_ready_0 = 1'b0;
    resp_ready_1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        have = 0; consumed = 0;
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        continue;
      end
      if (consumed) begin
        consumed = 0; have = 0; busy = 0;
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        check("resp_valid_after_consume", 32'({resp_valid_1, resp_valid_0}), 32'd0);
        continue;
      end
      if (resp_valid_0 || resp_valid_1) begin
        if (!have) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_resp: got valid=%b%b expected none", resp_valid_1, resp_valid_0);
          end else begin
            cur = exp_q.pop_front();
            have = 1;
            hold = hold_req;
            hold_req = 0;
          end
        end
        if (have) begin
          check("resp_port", 32'({resp_valid_1, resp_valid_0}), (cur.port == 1) ? 32'd2 : 32'd1);
          check("resp_data", 32'((cur.port == 1) ? resp_data_1 : resp_data_0), 32'(cur.data));
          if (hold > 0) begin
            hold--;
          end else if ($urandom_range(0, 2) != 0) begin
            if (cur.port == 1) resp_ready_1 = 1'b1;
            else               resp_ready_0 = 1'b1;
            consumed = 1;
          end
        end
      end
    end
  end

  // One clock of stimulus plus checks of the strobe/enable/mode outputs against the model.
  task automatic step();
    int   gp, slot;
    bit   inr, data_wr, do_rst;
    logic [N-1:0] we_exp;
    req_t q;
    resp_t r;
    @(negedge clk);
    #2;
    resetn = 1'b1;
    if (since_grant >= 0) since_grant++;
    for (int p = 0; p < 2; p++)
      if (gen_en && !has_pend[p] && $urandom_range(0, 1) == 1) begin
        pend[p] = rand_req();
        has_pend[p] = 1'b1;
      end
    run_en = 1'($urandom_range(0, 1));
    if (!busy) reg_value = RVW'($urandom);
    do_rst = exec_now && rst_in_exec;
    if (do_rst) resetn = 1'b0;
    req_valid_0 = has_pend[0]; req_write_0 = pend[0].write; req_addr_0 = pend[0].addr; req_data_0 = pend[0].data;
    req_valid_1 = has_pend[1]; req_write_1 = pend[1].write; req_addr_1 = pend[1].addr; req_data_1 = pend[1].data;
    #1;
    gp = -1;
    if (!busy) begin
      if (has_pend[0] && has_pend[1]) gp = 1 - last_port;
      else if (has_pend[0])           gp = 0;
      else if (has_pend[1])           gp = 1;
    end
    check("req_ready", 32'({req_ready_1, req_ready_0}), (gp == 1) ? 32'd2 : (gp == 0) ? 32'd1 : 32'd0);
    if (since_grant == 1) check("exec_no_resp", 32'({resp_valid_1, resp_valid_0}), 32'd0);
    if (since_grant == 2) begin
      check("resp_latency", 32'({resp_valid_1, resp_valid_0}), (lat_port == 1) ? 32'd2 : 32'd1);
      since_grant = -1;
    end
    we_exp = '0; data_wr = 0; slot = 0; inr = 0;
    if (exec_now) begin
      slot = int'(exec_req.addr[AW-1:0]);
      inr = slot < N;
      data_wr = exec_req.write && !exec_req.addr[AW];
      if (data_wr && inr && !do_rst) we_exp[slot] = 1'b1;
    end
    check("config_we", 32'(config_we), 32'(we_exp));
    check("clk_en", 32'(clk_en), 32'(run_en && !data_wr && !do_rst));
    check("config_data", 32'(config_data), 32'(m_cfg));
    check("mode", 32'(mode), 32'(mode_vec()));
    if (exec_now) begin
      if (exec_req.write && exec_req.addr[AW] && inr && !do_rst) m_mode[slot] = exec_req.data[1:0];
      exec_now = 0;
    end
    if (do_rst) begin
      for (int s = 0; s < N; s++) m_mode[s] = 2'b00;
      m_cfg = '0; busy = 0; last_port = 1; since_grant = -1; rst_in_exec = 0;
      void'(exp_q.pop_back());
    end
    if (gp >= 0) begin
      q = pend[gp];
      slot = int'(q.addr[AW-1:0]);
      inr = slot < N;
      r.port = gp;
      if (q.write)          r.data = q.data;
      else if (!inr)        r.data = '0;
      else if (q.addr[AW])  r.data = W'(m_mode[slot]);
      else                  r.data = reg_value[slot*W +: W];
      exp_q.push_back(r);
      if (q.write && !q.addr[AW]) m_cfg = q.data;
      busy = 1; last_port = gp; exec_now = 1; exec_req = q;
      has_pend[gp] = 0; since_grant = 0; lat_port = gp;
      grant_log.push_back(gp);
      if (refill > 0) begin
        refill--;
        pend[gp] = rand_req();
        has_pend[gp] = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < 80) begin
      step();
      n++;
      done = !busy && !exec_now && !has_pend[0] && !has_pend[1] && (exp_q.size() == 0);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
  endtask

  initial begin
    int start;
    resetn = 1'b0;
    req_valid_0 = 0; req_write_0 = 0; req_addr_0 = '0; req_data_0 = '0;
    req_valid_1 = 0; req_write_1 = 0; req_addr_1 = '0; req_data_1 = '0;
    run_en = 1'b1; reg_value = '0;
    busy = 0; last_port = 1; m_cfg = '0; exec_now = 0; rst_in_exec = 0;
    gen_en = 0; refill = 0; hold_req = 0; since_grant = -1; lat_port = 0;
    has_pend[0] = 0; has_pend[1] = 0;
    for (int s = 0; s < N; s++) m_mode[s] = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    check("rst_req_ready", 32'({req_ready_1, req_ready_0}), 32'd0);
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_config_we", 32'(config_we), 32'd0);
    check("rst_resp_valid", 32'({resp_valid_1, resp_valid_0}), 32'd0);
    check("rst_resp_data", 32'({resp_data_1, resp_data_0}), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_config_data", 32'(config_data), 32'd0);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;

    // Data write to slot 1 from port 0.
    pend[0] = mk(1'b1, 3'b001, 4'hA); has_pend[0] = 1'b1;
    wait_idle("data_write");

    // Mode write then mode read of slot 2 from port 1.
    pend[1] = mk(1'b1, 3'b110, 4'h1); has_pend[1] = 1'b1;
    wait_idle("mode_write");
    pend[1] = mk(1'b0, 3'b110, 4'h0); has_pend[1] = 1'b1;
    wait_idle("mode_read");

    // Both ports continuously valid: grants must alternate.
    start = grant_log.size();
    pend[0] = rand_req(); has_pend[0] = 1'b1;
    pend[1] = rand_req(); has_pend[1] = 1'b1;
    refill = 6;
    wait_idle("alternate");
    for (int i = start + 1; i < grant_log.size(); i++)
      check("alternate_grant", 32'(grant_log[i] != grant_log[i-1]), 32'd1);

    // Read slot 2 with a held-off response while port 0 waits.
    hold_req = 5;
    pend[1] = mk(1'b0, 3'b010, 4'h0); has_pend[1] = 1'b1;
    step();
    pend[0] = mk(1'b1, 3'b000, 4'h6); has_pend[0] = 1'b1;
    wait_idle("held_resp");

    // Out-of-range slot 3: write, mode write, then reads.
    pend[0] = mk(1'b1, 3'b011, 4'h5); has_pend[0] = 1'b1;
    wait_idle("oor_write");
    pend[0] = mk(1'b1, 3'b111, 4'h2); has_pend[0] = 1'b1;
    wait_idle("oor_mode_write");
    pend[1] = mk(1'b0, 3'b011, 4'h0); has_pend[1] = 1'b1;
    wait_idle("oor_read");

    // Reset during the EXEC of a data write after setting a mode of 2'b11.
    pend[0] = mk(1'b1, 3'b100, 4'h3); has_pend[0] = 1'b1;
    wait_idle("mode_write_11");
    rst_in_exec = 1'b1;
    pend[0] = mk(1'b1, 3'b000, 4'hF); has_pend[0] = 1'b1;
    wait_idle("reset_exec");
    pend[1] = mk(1'b0, 3'b100, 4'h0); has_pend[1] = 1'b1;
    wait_idle("post_reset_read");

    // Random traffic.
    gen_en = 1'b1;
    repeat (400) step();
    gen_en = 1'b0;
    wait_idle("random");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
